cpu_step_ctrl: RTL and testbench

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_step_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run clock-enable controller for a small CPU, with key debounce.
// Define CPU_STEP_CTRL_BREAKPOINT_EN to enable the BREAK state (halt when PC hits BP_ADDR).
module cpu_step_ctrl #(
  parameter int DIV = 50000000,
  parameter int DEB = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN_SW,
  input  logic       STEP_KEY,
  input  logic [3:0] PC,
  input  logic [3:0] BP_ADDR,
  output logic       TICK,
  output logic       HALTED,
  output logic [1:0] STATE
);

  localparam int DIV_W = $clog2(DIV);
  localparam int DEB_W = $clog2(DEB + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB - 1);

  typedef enum logic [1:0] {
    ST_STEP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BREAK = 2'b10
  } state_e;

  logic             run_s1_q, run_s2_q;
  logic             key_s1_q, key_s2_q;
  logic             key_db_q, key_db_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             bp_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
      key_s1_q  <= 1'b1;
      key_s2_q  <= 1'b1;
      key_db_q  <= 1'b1;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      state_q   <= ST_STEP;
      div_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      run_s1_q  <= RUN_SW;
      run_s2_q  <= run_s1_q;
      key_s1_q  <= STEP_KEY;
      key_s2_q  <= key_s1_q;
      key_db_q  <= key_db_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
    end
  end

  // Any cycle where the synchronized level matches the accepted level restarts the count.
  always_comb begin
    key_db_d  = key_db_q;
    deb_cnt_d = '0;
    press_d   = 1'b0;
    if (key_s2_q != key_db_q) begin
      if (deb_cnt_q == DEB_MAX) begin
        key_db_d = key_s2_q;
        press_d  = ~key_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
  assign bp_hit = (PC == BP_ADDR);
  assign HALTED = (state_q == ST_BREAK);
`else
  logic unused_bp;
  assign unused_bp = ^{PC, BP_ADDR};
  assign bp_hit    = 1'b0;
  assign HALTED    = 1'b0;
`endif

  // Mode changes take priority over any TICK or press event due in the same cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_STEP: begin
        div_d = '0;
        if (run_s2_q) begin
          state_d = ST_RUN;
        end else if (press_q && !tick_q) begin
          tick_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_s2_q) begin
          state_d = ST_STEP;
          div_d   = '0;
        end else if (div_q == DIV_MAX) begin
          div_d = '0;
          if (bp_hit) begin
            state_d = ST_BREAK;
          end else begin
            tick_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_BREAK: begin
        div_d = '0;
        if (!run_s2_q) begin
          state_d = ST_STEP;
        end else if (press_q) begin
          state_d = ST_RUN;
          tick_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_STEP;
        div_d   = '0;
      end
    endcase
  end

  assign TICK  = tick_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl (DIV=4, DEB=3); a per-cycle reference model
// pushes expected outputs, a negedge monitor pops and compares them.
module tb_cpu_step_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, run_sw, step_key;
  logic [3:0] pc, bp;
  logic       tick, halted;
  logic [1:0] state;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .CLK(clk), .RST(rst), .RUN_SW(run_sw), .STEP_KEY(step_key),
    .PC(pc), .BP_ADDR(bp), .TICK(tick), .HALTED(halted), .STATE(state)
  );

  typedef struct packed {
    logic       tick;
    logic       halted;
    logic [1:0] state;
  } exp_t;

  exp_t exp_q[$];
  int   tick_log[$];
  int   assertions = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: raw inputs delayed two edges, key accepted once the last DEB
  // synchronized samples all disagree with the accepted level, run ticks every DIV
  // cycles measured from RUN entry.
  bit m_s1r, m_s2r, m_s1k, m_s2k, m_db, m_press, m_tick;
  int m_mode;  // 0 step, 1 run, 2 break
  int m_age;
  bit hist[$];

  always @(posedge clk) begin : model
    bit   n_db, n_press, n_tick, all_diff;
    int   n_mode;
    exp_t e;
    cyc++;
    if (rst) begin
      m_s1r = 0; m_s2r = 0; m_s1k = 1; m_s2k = 1;
      m_db = 1; m_press = 0; m_tick = 0; m_mode = 0; m_age = 0;
      hist.delete();
    end else begin
      n_db = m_db;
      n_press = 0;
      hist.push_back(m_s2k);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
        if (all_diff) begin
          n_db = !m_db;
          n_press = (n_db == 0);
          hist.delete();
        end
      end
      n_tick = 0;
      n_mode = m_mode;
      case (m_mode)
        0: if (m_s2r) begin n_mode = 1; m_age = 0; end
           else if (m_press) n_tick = 1;
        1: if (!m_s2r) n_mode = 0;
           else begin
             m_age++;
             if (m_age % DIV == 0) begin
               if (BP_EN && pc == bp) n_mode = 2;
               else n_tick = 1;
             end
           end
        default: if (!m_s2r) n_mode = 0;
           else if (m_press) begin n_mode = 1; m_age = 0; n_tick = 1; end
      endcase
      m_s2r = m_s1r; m_s1r = run_sw;
      m_s2k = m_s1k; m_s1k = step_key;
      m_db = n_db; m_press = n_press; m_mode = n_mode; m_tick = n_tick;
    end
    e.tick = m_tick;
    e.halted = (m_mode == 2);
    e.state = 2'(m_mode);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      assertions++;
      if ({tick, halted, state} !== e) begin
        failures++;
        $display("FAIL outputs cycle %0d: tick/halted/state got %b/%b/%b expected %b/%b/%b",
                 cyc, tick, halted, state, e.tick, e.halted, e.state);
      end
      if (tick === 1'b1) begin
        tick_log.push_back(cyc);
        $display("cycle %0d: TICK state=%b halted=%b", cyc, state, halted);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    assertions++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int count_ticks(input int lo, input int hi);
    int n = 0;
    foreach (tick_log[i]) if (tick_log[i] > lo && tick_log[i] <= hi) n++;
    return n;
  endfunction

  function automatic int first_tick(input int lo, input int hi);
    foreach (tick_log[i]) if (tick_log[i] > lo && tick_log[i] <= hi) return tick_log[i];
    return -1;
  endfunction

  task automatic wait_tick(output int t);
    int n0 = tick_log.size();
    t = -1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick_log.size() > n0) begin
        t = tick_log[n0];
        break;
      end
    end
    if (t < 0) begin
      assertions++;
      failures++;
      $display("FAIL wait_tick: got no TICK expected one within 20 cycles");
    end
  endtask

  initial begin
    int t0, t1, tt;
    rst = 1; run_sw = 0; step_key = 1; pc = 4'd0; bp = 4'd5;
    step(3);
    check("reset tick", int'(tick), 0);
    check("reset state", int'(state), 0);
    check("reset halted", int'(halted), 0);
    rst = 0;
    step(10);

    // one clean press: single TICK six cycles after the key falls
    t0 = cyc;
    step_key = 0; step(5);
    step_key = 1; step(15);
    check("press tick count", count_ticks(t0, cyc), 1);
    check("press tick cycle", first_tick(t0, cyc), t0 + 6);

    // bounce every cycle: never stable long enough to be accepted
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      step_key = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    step_key = 1; step(15);
    check("bounce tick count", count_ticks(t0, cyc), 0);

    // random key activity in STEP mode
    for (int i = 0; i < 40; i++) begin
      step_key = 1'($urandom_range(0, 1));
      step($urandom_range(1, 6));
    end
    step_key = 1; step(10);

    // free run: RUN after 3 cycles, TICK every DIV cycles
    t0 = cyc;
    run_sw = 1; step(24);
    check("run tick count", count_ticks(t0, cyc), 5);
    check("run first tick", first_tick(t0, cyc), t0 + 7);
    // leave RUN exactly on a due cycle: that TICK is dropped
    t1 = cyc;
    run_sw = 0; step(8);
    check("drop-on-due ticks", count_ticks(t1, cyc), 0);
    check("back to step", int'(state), 0);

    // reset on a due cycle aborts the TICK
    run_sw = 1;
    wait_tick(tt);
    step(2);
    rst = 1; step(1);
    check("rst due tick", int'(tick), 0);
    check("rst due state", int'(state), 0);
    check("rst due halted", int'(halted), 0);
    rst = 0;

    // PC at breakpoint address while running
    pc = 4'd5; bp = 4'd5;
    t0 = cyc;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    step(8);
    check("bp no tick", count_ticks(t0, cyc), 0);
    check("bp state", int'(state), 2);
    check("bp halted", int'(halted), 1);
    t1 = cyc;
    step_key = 0; step(5);
    step_key = 1; step(3);
    check("bp resume ticks", count_ticks(t1, cyc), 1);
    check("bp resume state", int'(state), 1);
    check("bp resume halted", int'(halted), 0);
`else
    step(20);
    check("nobp tick count", count_ticks(t0, cyc), 4);
    check("nobp halted", int'(halted), 0);
    check("nobp state", int'(state), 1);
`endif

    // random mixed operation
    for (int i = 0; i < 150; i++) begin
      run_sw = 1'($urandom_range(0, 1));
      step_key = 1'($urandom_range(0, 1));
      pc = ($urandom_range(0, 2) == 0) ? bp : 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 29) == 0);
      step($urandom_range(1, 10));
      rst = 0;
    end
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
